// File: rtl/l2_fence_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_fence_ctrl_pkg : default geometry and FSM state type for the       |
// | L2 fence/drain sequencer.                     Rev 1.0                |
// +----------------------------------------------------------------------+
package l2_fence_ctrl_pkg;

  localparam int unsigned L2_SETS = 4;
  localparam int unsigned L2_WAYS = 2;
  localparam int unsigned N_MSHR  = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    WAIT = 3'd2,
    INV  = 3'd3,
    DONE = 3'd4
  } l2_fence_state_t;

endpackage
`default_nettype wire

// File: rtl/l2_drain_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_drain_ptr : set/way walk pointer with advance, clear and a        |
// | last-slot flag.                               Rev 1.0                |
// +----------------------------------------------------------------------+
module l2_drain_ptr #(
  parameter int unsigned N_SETS = 4,
  parameter int unsigned N_WAYS = 2,
  localparam int unsigned SET_BITS = $clog2(N_SETS),
  localparam int unsigned WAY_BITS = $clog2(N_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                adv_i,
  output logic [SET_BITS-1:0] set_o,
  output logic [WAY_BITS-1:0] way_o,
  output logic                last_o
);

  logic [SET_BITS-1:0] set_q, set_d;
  logic [WAY_BITS-1:0] way_q, way_d;

  assign set_o  = set_q;
  assign way_o  = way_q;
  assign last_o = (set_q == SET_BITS'(N_SETS - 1)) && (way_q == WAY_BITS'(N_WAYS - 1));

  // Power-of-two geometry means advancing past the last slot wraps to (0,0).
  always_comb begin
    set_d = set_q;
    way_d = way_q;
    if (clr_i) begin
      set_d = '0;
      way_d = '0;
    end else if (adv_i) begin
      if (way_q == WAY_BITS'(N_WAYS - 1)) begin
        way_d = '0;
        set_d = set_q + SET_BITS'(1);
      end else begin
        way_d = way_q + WAY_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_q <= '0;
      way_q <= '0;
    end else begin
      set_q <= set_d;
      way_q <= way_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_fence_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_fence_ctrl : fence/drain sequencer feeding the L2 input decoder.  |
// | Optional perf counters under `L2_FENCE_PERF_EN.  Rev 1.0             |
// +----------------------------------------------------------------------+
module l2_fence_ctrl
  import l2_fence_ctrl_pkg::*;
#(
  parameter int unsigned N_SETS   = L2_SETS,
  parameter int unsigned N_WAYS   = L2_WAYS,
  parameter int unsigned N_MSHR_P = N_MSHR,
  localparam int unsigned SET_BITS = $clog2(N_SETS),
  localparam int unsigned WAY_BITS = $clog2(N_WAYS),
  localparam int unsigned CNT_BITS = $clog2(N_MSHR_P + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                do_fence,
  input  logic                fence_acq,
  input  logic                fence_rel,
  input  logic                do_ongoing_fence,
  input  logic                clr_ongoing_drain,
  input  logic [CNT_BITS-1:0] mshr_cnt,
  output logic                ongoing_fence,
  output logic                ongoing_drain,
  output logic                drain_in_progress,
  output logic [SET_BITS-1:0] drain_set,
  output logic [WAY_BITS-1:0] drain_way,
  output logic                self_inv,
  output logic                fence_done
`ifdef L2_FENCE_PERF_EN
  ,
  output logic [31:0]         fence_cycles,
  output logic [15:0]         fence_count
`endif
);

  l2_fence_state_t state_q, state_d;
  logic acq_q, acq_d, rel_q, rel_d;
  logic fence_q, fence_d;
  logic drain_q, drain_d;
  logic dip_q, dip_d;
  logic inv_q, inv_d;
  logic done_q, done_d;
  logic ptr_clr, ptr_adv, ptr_last;

  l2_drain_ptr #(
    .N_SETS (N_SETS),
    .N_WAYS (N_WAYS)
  ) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (ptr_clr),
    .adv_i  (ptr_adv),
    .set_o  (drain_set),
    .way_o  (drain_way),
    .last_o (ptr_last)
  );

  always_comb begin
    state_d = state_q;
    acq_d   = acq_q;
    rel_d   = rel_q;
    fence_d = fence_q;
    drain_d = drain_q;
    dip_d   = dip_q;
    ptr_clr = 1'b0;
    ptr_adv = 1'b0;

    if (clr_ongoing_drain) drain_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (do_fence) begin
          acq_d   = fence_acq;
          rel_d   = fence_rel;
          fence_d = 1'b1;
          if (fence_rel) begin
            state_d = SCAN;
            ptr_clr = 1'b1;
          end else if (fence_acq) begin
            state_d = INV;
          end else begin
            state_d = DONE;
          end
        end
      end
      SCAN: begin
        if (do_ongoing_fence && rel_q) begin
          ptr_adv = 1'b1;
          if (ptr_last) begin
            state_d = WAIT;
            dip_d   = 1'b1;
            drain_d = 1'b1;  // overrides a same-cycle clear
          end
        end
      end
      WAIT: begin
        if (mshr_cnt == CNT_BITS'(N_MSHR_P)) begin
          dip_d   = 1'b0;
          state_d = acq_q ? INV : DONE;
        end
      end
      INV:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // fence_done rises on the same edge that drops ongoing_fence.
    if ((state_d == DONE) && (state_q != DONE)) begin
      fence_d = 1'b0;
      acq_d   = 1'b0;
      rel_d   = 1'b0;
    end
  end

  assign inv_d  = (state_d == INV);
  assign done_d = (state_d == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acq_q   <= 1'b0;
      rel_q   <= 1'b0;
      fence_q <= 1'b0;
      drain_q <= 1'b0;
      dip_q   <= 1'b0;
      inv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acq_q   <= acq_d;
      rel_q   <= rel_d;
      fence_q <= fence_d;
      drain_q <= drain_d;
      dip_q   <= dip_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
    end
  end

  assign ongoing_fence     = fence_q;
  assign ongoing_drain     = drain_q;
  assign drain_in_progress = dip_q;
  assign self_inv          = inv_q;
  assign fence_done        = done_q;

`ifdef L2_FENCE_PERF_EN
  logic [31:0] cycles_q;
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_q <= '0;
      count_q  <= '0;
    end else begin
      if (fence_q && (cycles_q != '1)) cycles_q <= cycles_q + 32'd1;
      if (done_q) count_q <= count_q + 16'd1;
    end
  end

  assign fence_cycles = cycles_q;
  assign fence_count  = count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_fence_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_l2_fence_ctrl : scoreboard bench for l2_fence_ctrl (4 sets,       |
// | 2 ways, 4 MSHRs).                             Rev 1.0                |
// +----------------------------------------------------------------------+
module tb_l2_fence_ctrl;

  localparam int NS = 4;
  localparam int NW = 2;
  localparam int NM = 4;

  localparam int K_SLOT = 0;
  localparam int K_INV  = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int kind;
    int set;
    int way;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       do_fence = 1'b0;
  logic       fence_acq = 1'b0;
  logic       fence_rel = 1'b0;
  logic       do_ongoing_fence = 1'b0;
  logic       clr_ongoing_drain = 1'b0;
  logic [2:0] mshr_cnt = 3'(NM);
  logic       ongoing_fence, ongoing_drain, drain_in_progress;
  logic [1:0] drain_set;
  logic       drain_way;
  logic       self_inv, fence_done;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   sp = 0;
  int   wp = 0;
  int   t0;

  l2_fence_ctrl #(
    .N_SETS   (NS),
    .N_WAYS   (NW),
    .N_MSHR_P (NM)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .do_fence          (do_fence),
    .fence_acq         (fence_acq),
    .fence_rel         (fence_rel),
    .do_ongoing_fence  (do_ongoing_fence),
    .clr_ongoing_drain (clr_ongoing_drain),
    .mshr_cnt          (mshr_cnt),
    .ongoing_fence     (ongoing_fence),
    .ongoing_drain     (ongoing_drain),
    .drain_in_progress (drain_in_progress),
    .drain_set         (drain_set),
    .drain_way         (drain_way),
    .self_inv          (self_inv),
    .fence_done        (fence_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (rst && do_fence)
      assert (!ongoing_fence && !fence_done) else $error("do_fence issued while a fence is active");

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int s, input int w, input int c);
    exp_t e;
    e.kind = kind; e.set = s; e.way = w; e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic observe(input int kind, input int s, input int w);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected kind %0d set %0d way %0d at cycle %0d", kind, s, w, cyc);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind || e.set != s || e.way != w || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind %0d set %0d way %0d cycle %0d want kind %0d set %0d way %0d cycle %0d",
                 kind, s, w, cyc, e.kind, e.set, e.way, e.cyc);
      end
    end
  endtask

  // Monitor: every drain slot, self_inv pulse and fence_done pulse is scored.
  always @(negedge clk) begin
    if (rst) begin
      if (do_ongoing_fence) observe(K_SLOT, int'(drain_set), int'(drain_way));
      if (self_inv)         observe(K_INV, 0, 0);
      if (fence_done)       observe(K_DONE, 0, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fence(input logic acq, input logic rel);
    do_fence = 1'b1; fence_acq = acq; fence_rel = rel;
    t0 = cyc;
    if (rel) begin sp = 0; wp = 0; end
    tick();
    do_fence = 1'b0; fence_acq = 1'b0; fence_rel = 1'b0;
  endtask

  task automatic grant();
    push(K_SLOT, sp, wp, cyc);
    do_ongoing_fence = 1'b1;
    tick();
    do_ongoing_fence = 1'b0;
    if (wp == NW - 1) begin wp = 0; sp = (sp + 1) % NS; end
    else wp = wp + 1;
  endtask

  function automatic logic [7:0] outs();
    return {ongoing_fence, ongoing_drain, drain_in_progress, drain_set, drain_way, self_inv, fence_done};
  endfunction

  initial begin
    #1;
    chk("reset_outputs", 32'(outs()), 32'h0);
    idle(2);
    rst = 1'b1;
    idle(2);

    // Release fence, grant every cycle: fence_done 10 cycles after do_fence.
    fence(1'b0, 1'b1);
    chk("rel_fence_on", 32'(ongoing_fence), 32'h1);
    for (int i = 0; i < NS * NW; i++) grant();
    push(K_DONE, 0, 0, t0 + 10);
    chk("rel_dip_hi", 32'(drain_in_progress), 32'h1);
    chk("rel_drain_hi", 32'(ongoing_drain), 32'h1);
    chk("rel_ptr_zero", 32'({drain_set, drain_way}), 32'h0);
    tick();
    chk("rel_dip_lo", 32'(drain_in_progress), 32'h0);
    chk("rel_fence_off", 32'(ongoing_fence), 32'h0);
    clr_ongoing_drain = 1'b1;
    tick();
    clr_ongoing_drain = 1'b0;
    chk("rel_drain_clr", 32'(ongoing_drain), 32'h0);
    idle(2);

    // Release fence with grants on every third cycle.
    fence(1'b0, 1'b1);
    for (int i = 0; i < NS * NW; i++) begin
      grant();
      if (i != NS * NW - 1) idle(2);
    end
    push(K_DONE, 0, 0, cyc + 1);
    idle(3);

    // Acquire+release, MSHRs busy for 5 WAIT cycles; clear races the drain set.
    mshr_cnt = 3'(NM - 2);
    clr_ongoing_drain = 1'b1;
    fence(1'b1, 1'b1);
    for (int i = 0; i < NS * NW; i++) grant();
    push(K_INV, 0, 0, cyc + 6);
    push(K_DONE, 0, 0, cyc + 7);
    chk("ar_drain_set_wins", 32'(ongoing_drain), 32'h1);
    chk("ar_dip_hi", 32'(drain_in_progress), 32'h1);
    tick();
    clr_ongoing_drain = 1'b0;
    chk("ar_drain_clr", 32'(ongoing_drain), 32'h0);
    idle(4);
    chk("ar_dip_still_hi", 32'(drain_in_progress), 32'h1);
    mshr_cnt = 3'(NM);
    tick();
    chk("ar_dip_lo", 32'(drain_in_progress), 32'h0);
    chk("ar_fence_in_inv", 32'(ongoing_fence), 32'h1);
    tick();
    chk("ar_fence_off", 32'(ongoing_fence), 32'h0);
    idle(2);

    // Acquire-only: no scan, self_inv then fence_done.
    fence(1'b1, 1'b0);
    push(K_INV, 0, 0, t0 + 1);
    push(K_DONE, 0, 0, t0 + 2);
    chk("acq_no_drain", 32'(ongoing_drain), 32'h0);
    chk("acq_no_dip", 32'(drain_in_progress), 32'h0);
    idle(3);

    // Plain fence (neither semantics): straight to DONE.
    fence(1'b0, 1'b0);
    push(K_DONE, 0, 0, t0 + 1);
    idle(3);

    // Reset mid-scan at pointer (2,1), then a clean restart.
    fence(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) grant();
    chk("rst_ptr_at_2_1", 32'({drain_set, drain_way}), 32'h5);
    rst = 1'b0;
    #1;
    chk("rst_async_outputs", 32'(outs()), 32'h0);
    tick();
    rst = 1'b1;
    idle(3);
    chk("rst_no_fence", 32'(ongoing_fence), 32'h0);
    fence(1'b0, 1'b1);
    chk("rst_restart_ptr", 32'({drain_set, drain_way}), 32'h0);
    for (int i = 0; i < NS * NW; i++) grant();
    push(K_DONE, 0, 0, cyc + 1);
    idle(4);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d pending want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
